// File: rtl/store_aligner.sv
// Store aligner: turns a MEM-stage store into word-aligned, byte-strobed write beats.
// Optional macro SPLIT_MISALIGNED_EN enables splitting cross-word stores into two beats.
module store_aligner (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        Req_valid_i,
  output logic        Req_ready_o,
  input  logic [31:0] Addr_i,
  input  logic [31:0] Data_i,
  input  logic [1:0]  Size_i,
  output logic        Mem_valid_o,
  input  logic        Mem_ready_i,
  output logic [31:0] Mem_addr_o,
  output logic [31:0] Mem_data_o,
  output logic [3:0]  Mem_strb_o,
  output logic        Busy_o,
  output logic        Store_err_o
);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef SPLIT_MISALIGNED_EN
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;
`else
  typedef enum logic [1:0] {IDLE, BEAT0} state_t;
`endif

  function automatic logic [3:0] base_mask(input logic [1:0] size);
    case (size)
      SZ_BYTE: base_mask = 4'b0001;
      SZ_HALF: base_mask = 4'b0011;
      SZ_WORD: base_mask = 4'b1111;
      default: base_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] size_data(input logic [31:0] data, input logic [1:0] size);
    case (size)
      SZ_BYTE: size_data = {24'b0, data[7:0]};
      SZ_HALF: size_data = {16'b0, data[15:0]};
      SZ_WORD: size_data = data;
      default: size_data = 32'b0;
    endcase
  endfunction

  state_t      state_q, state_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_data_q, mem_data_d;
  logic [3:0]  mem_strb_q, mem_strb_d;
  logic        err_q, err_d;

  logic [1:0]  off;
  logic [7:0]  strb_sh;
  logic [31:0] beat0_data;
  logic        cross_word;
  logic        illegal_size;
  logic        accept;

  assign off          = Addr_i[1:0];
  assign strb_sh      = {4'b0000, base_mask(Size_i)} << off;
  assign cross_word   = (strb_sh[7:4] != 4'b0000);
  assign illegal_size = (Size_i == 2'b11);
  assign Req_ready_o  = (state_q == IDLE);
  assign accept       = Req_valid_i && Req_ready_o;

`ifdef SPLIT_MISALIGNED_EN
  logic [63:0] data_sh;
  logic [31:0] hi_data_q, hi_data_d;
  logic [3:0]  hi_strb_q, hi_strb_d;

  assign data_sh    = {32'b0, size_data(Data_i, Size_i)} << {off, 3'b000};
  assign beat0_data = data_sh[31:0];
`else
  assign beat0_data = size_data(Data_i, Size_i) << {off, 3'b000};
`endif

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    mem_strb_d  = mem_strb_q;
    err_d       = 1'b0;
`ifdef SPLIT_MISALIGNED_EN
    hi_data_d   = hi_data_q;
    hi_strb_d   = hi_strb_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
`ifdef SPLIT_MISALIGNED_EN
          if (illegal_size) begin
`else
          // Without splitting, a store that spills into the next word cannot be issued.
          if (illegal_size || cross_word) begin
`endif
            err_d = 1'b1;
          end else begin
            state_d     = BEAT0;
            mem_valid_d = 1'b1;
            mem_addr_d  = {Addr_i[31:2], 2'b00};
            mem_strb_d  = strb_sh[3:0];
            mem_data_d  = beat0_data;
`ifdef SPLIT_MISALIGNED_EN
            hi_strb_d   = strb_sh[7:4];
            hi_data_d   = data_sh[63:32];
`endif
          end
        end
      end
      BEAT0: begin
        if (Mem_ready_i) begin
`ifdef SPLIT_MISALIGNED_EN
          if (hi_strb_q != 4'b0000) begin
            // Address wraps naturally at the top of the 32-bit space.
            state_d    = BEAT1;
            mem_addr_d = mem_addr_q + 32'd4;
            mem_strb_d = hi_strb_q;
            mem_data_d = hi_data_q;
          end else begin
            state_d     = IDLE;
            mem_valid_d = 1'b0;
            mem_strb_d  = 4'b0000;
            mem_data_d  = 32'b0;
          end
`else
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_strb_d  = 4'b0000;
          mem_data_d  = 32'b0;
`endif
        end
      end
`ifdef SPLIT_MISALIGNED_EN
      BEAT1: begin
        if (Mem_ready_i) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          mem_strb_d  = 4'b0000;
          mem_data_d  = 32'b0;
        end
      end
`endif
      default: begin
        state_d     = IDLE;
        mem_valid_d = 1'b0;
        mem_strb_d  = 4'b0000;
        mem_data_d  = 32'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= 32'b0;
      mem_data_q  <= 32'b0;
      mem_strb_q  <= 4'b0000;
      err_q       <= 1'b0;
`ifdef SPLIT_MISALIGNED_EN
      hi_strb_q   <= 4'b0000;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      mem_strb_q  <= mem_strb_d;
      err_q       <= err_d;
`ifdef SPLIT_MISALIGNED_EN
      hi_strb_q   <= hi_strb_d;
`endif
    end
  end

`ifdef SPLIT_MISALIGNED_EN
  // Second-beat data is only consumed after its strobe is captured, so it needs no reset.
  always_ff @(posedge clk_i) begin
    hi_data_q <= hi_data_d;
  end
`endif

  assign Mem_valid_o = mem_valid_q;
  assign Mem_addr_o  = mem_addr_q;
  assign Mem_data_o  = mem_data_q;
  assign Mem_strb_o  = mem_strb_q;
  assign Busy_o      = (state_q != IDLE);
  assign Store_err_o = err_q;

endmodule

// File: tb/tb_store_aligner.sv
// Directed, table-driven bench for store_aligner; expectations follow SPLIT_MISALIGNED_EN.
module tb_store_aligner;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        Req_valid_i = 1'b0;
  logic        Req_ready_o;
  logic [31:0] Addr_i = 32'b0;
  logic [31:0] Data_i = 32'b0;
  logic [1:0]  Size_i = 2'b00;
  logic        Mem_valid_o;
  logic        Mem_ready_i = 1'b1;
  logic [31:0] Mem_addr_o;
  logic [31:0] Mem_data_o;
  logic [3:0]  Mem_strb_o;
  logic        Busy_o;
  logic        Store_err_o;

  int total = 0;
  int bad   = 0;

  store_aligner dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .Req_valid_i (Req_valid_i),
    .Req_ready_o (Req_ready_o),
    .Addr_i      (Addr_i),
    .Data_i      (Data_i),
    .Size_i      (Size_i),
    .Mem_valid_o (Mem_valid_o),
    .Mem_ready_i (Mem_ready_i),
    .Mem_addr_o  (Mem_addr_o),
    .Mem_data_o  (Mem_data_o),
    .Mem_strb_o  (Mem_strb_o),
    .Busy_o      (Busy_o),
    .Store_err_o (Store_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          beats;
    logic [31:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0;
    logic [31:0] a1;
    logic [3:0]  s1;
    logic [31:0] d1;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    @(negedge clk_i);
    check("ready_before_req", {31'b0, Req_ready_o}, 32'd1);
    Req_valid_i = 1'b1;
    Addr_i      = a;
    Data_i      = d;
    Size_i      = s;
    @(posedge clk_i);
    #1;
    Req_valid_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    send_req(v.addr, v.data, v.size);
    if (v.beats == 0) begin
      check($sformatf("v%0d_err_pulse", id), {31'b0, Store_err_o}, 32'd1);
      check($sformatf("v%0d_no_valid", id), {31'b0, Mem_valid_o}, 32'd0);
      check($sformatf("v%0d_not_busy", id), {31'b0, Busy_o}, 32'd0);
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_err_clear", id), {31'b0, Store_err_o}, 32'd0);
      check($sformatf("v%0d_no_valid2", id), {31'b0, Mem_valid_o}, 32'd0);
    end else begin
      check($sformatf("v%0d_valid0", id), {31'b0, Mem_valid_o}, 32'd1);
      check($sformatf("v%0d_addr0", id), Mem_addr_o, v.a0);
      check($sformatf("v%0d_strb0", id), {28'b0, Mem_strb_o}, {28'b0, v.s0});
      check($sformatf("v%0d_data0", id), Mem_data_o, v.d0);
      check($sformatf("v%0d_busy0", id), {31'b0, Busy_o}, 32'd1);
      check($sformatf("v%0d_ready0", id), {31'b0, Req_ready_o}, 32'd0);
      check($sformatf("v%0d_noerr", id), {31'b0, Store_err_o}, 32'd0);
      if (v.beats == 2) begin
        @(posedge clk_i);
        #1;
        check($sformatf("v%0d_valid1", id), {31'b0, Mem_valid_o}, 32'd1);
        check($sformatf("v%0d_addr1", id), Mem_addr_o, v.a1);
        check($sformatf("v%0d_strb1", id), {28'b0, Mem_strb_o}, {28'b0, v.s1});
        check($sformatf("v%0d_data1", id), Mem_data_o, v.d1);
      end
      @(posedge clk_i);
      #1;
      check($sformatf("v%0d_done_valid", id), {31'b0, Mem_valid_o}, 32'd0);
      check($sformatf("v%0d_done_ready", id), {31'b0, Req_ready_o}, 32'd1);
      check($sformatf("v%0d_done_busy", id), {31'b0, Busy_o}, 32'd0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, {31'b0, Mem_valid_o}, 32'd0);
    check({tag, "_addr"}, Mem_addr_o, 32'd0);
    check({tag, "_data"}, Mem_data_o, 32'd0);
    check({tag, "_strb"}, {28'b0, Mem_strb_o}, 32'd0);
    check({tag, "_busy"}, {31'b0, Busy_o}, 32'd0);
    check({tag, "_ready"}, {31'b0, Req_ready_o}, 32'd1);
    check({tag, "_err"}, {31'b0, Store_err_o}, 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'h0, 4'b0, 32'h0};
    vecs[1] = '{32'h0000_0103, 32'h1234_56AB, 2'b00, 1, 32'h0000_0100, 4'b1000, 32'hAB00_0000, 32'h0, 4'b0, 32'h0};
    vecs[2] = '{32'h0000_0202, 32'h0000_CAFE, 2'b01, 1, 32'h0000_0200, 4'b1100, 32'hCAFE_0000, 32'h0, 4'b0, 32'h0};
    vecs[3] = '{32'h0000_0201, 32'hFFFF_1234, 2'b01, 1, 32'h0000_0200, 4'b0110, 32'h0012_3400, 32'h0, 4'b0, 32'h0};
    vecs[4] = '{32'h0000_0001, 32'hFFFF_FF5A, 2'b00, 1, 32'h0000_0000, 4'b0010, 32'h0000_5A00, 32'h0, 4'b0, 32'h0};
    vecs[5] = '{32'h0000_0040, 32'h1111_2222, 2'b11, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
`ifdef SPLIT_MISALIGNED_EN
    vecs[6] = '{32'h0000_0203, 32'h0000_CAFE, 2'b01, 2, 32'h0000_0200, 4'b1000, 32'hFE00_0000, 32'h0000_0204, 4'b0001, 32'h0000_00CA};
    vecs[7] = '{32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 2, 32'hFFFF_FFFC, 4'b1100, 32'h3344_0000, 32'h0000_0000, 4'b0011, 32'h0000_1122};
    vecs[8] = '{32'h0000_0305, 32'hAABB_CCDD, 2'b10, 2, 32'h0000_0304, 4'b1110, 32'hBBCC_DD00, 32'h0000_0308, 4'b0001, 32'h0000_00AA};
`else
    vecs[6] = '{32'h0000_0203, 32'h0000_CAFE, 2'b01, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[7] = '{32'hFFFF_FFFE, 32'h1122_3344, 2'b10, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
    vecs[8] = '{32'h0000_0305, 32'hAABB_CCDD, 2'b10, 0, 32'h0, 4'b0, 32'h0, 32'h0, 4'b0, 32'h0};
`endif

    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    check_reset_outputs("post_reset");

    for (int i = 0; i < 9; i++) begin
      run_vec(vecs[i], i);
    end

    // Backpressure: beat must hold for three stalled cycles, then complete.
    Mem_ready_i = 1'b0;
    send_req(32'h0000_0040, 32'h0102_0304, 2'b10);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) begin
        @(posedge clk_i);
        #1;
      end
      check($sformatf("stall%0d_valid", c), {31'b0, Mem_valid_o}, 32'd1);
      check($sformatf("stall%0d_addr", c), Mem_addr_o, 32'h0000_0040);
      check($sformatf("stall%0d_strb", c), {28'b0, Mem_strb_o}, 32'h0000_000F);
      check($sformatf("stall%0d_data", c), Mem_data_o, 32'h0102_0304);
      check($sformatf("stall%0d_ready", c), {31'b0, Req_ready_o}, 32'd0);
    end
    @(negedge clk_i);
    Mem_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("stall_done_valid", {31'b0, Mem_valid_o}, 32'd0);
    check("stall_done_ready", {31'b0, Req_ready_o}, 32'd1);

    // Reset while a beat is in flight.
`ifdef SPLIT_MISALIGNED_EN
    send_req(32'h0000_0203, 32'h0000_CAFE, 2'b01);
    @(posedge clk_i);
    #1;
    check("midrst_beat1_valid", {31'b0, Mem_valid_o}, 32'd1);
    check("midrst_beat1_addr", Mem_addr_o, 32'h0000_0204);
    Mem_ready_i = 1'b0;
`else
    Mem_ready_i = 1'b0;
    send_req(32'h0000_0080, 32'hCAFE_F00D, 2'b10);
    check("midrst_beat0_valid", {31'b0, Mem_valid_o}, 32'd1);
`endif
    #1 rst_i = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(negedge clk_i);
    rst_i = 1'b0;
    Mem_ready_i = 1'b1;
    run_vec(vecs[0], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_aligner.md
# store_aligner

Store-path counterpart of the load extender: accepts a store request (address, register data, size) from the MEM stage and converts it into word-aligned data-memory write beats. Each beat carries byte-lane-shifted data and a 4-bit byte strobe. Misaligned stores that cross a word boundary are split into two sequential beats. A valid/ready handshake toward data memory lets the pipeline stall on memory backpressure.

## Interface
- No parameters; data/address width fixed at 32. Size encoding is shared with the load-path definitions header: Byte = 2'b00, Half = 2'b01, Word = 2'b10, 2'b11 illegal.
- Clocking/reset (already decided): one clock; reset is asynchronous and active-high.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- Req_valid_i  input  1  store request present.
- Req_ready_o  output  1  block can accept a request; high only in IDLE.
- Addr_i  input  32  byte address of store.
- Data_i  input  32  rs2 value; only the low 1/2/4 bytes are used per Size_i.
- Size_i  input  2  store size.
- Mem_valid_o  output  1  write beat valid.
- Mem_ready_i  input  1  memory accepts beat.
- Mem_addr_o  output  32  word-aligned beat address, bits [1:0] always 0.
- Mem_data_o  output  32  lane-aligned write data; lanes with strobe 0 are driven 0.
- Mem_strb_o  output  4  byte enables; bit k = byte lane k.
- Busy_o  output  1  high in BEAT0/BEAT1.
- Store_err_o  output  1  one-cycle pulse: request dropped.

## Operation
- States: IDLE, BEAT0, BEAT1.
- Accept: Req_valid_i && Req_ready_o. All request fields are captured into registers on the accept edge.
- Beat computation:
  - off = Addr_i[1:0].
  - base mask = 4'b0001 (Byte), 4'b0011 (Half), 4'b1111 (Word).
  - 8-bit strobe S = {4'b0, base} << off.
  - 64-bit data D = {32'b0, Data_i masked to size} << (8*off).
  - BEAT0: addr = {Addr_i[31:2], 2'b00}, strb = S[3:0], data = D[31:0].
  - BEAT1: addr = BEAT0 addr + 4 (mod 2^32, so 0xFFFFFFFC wraps to 0x00000000), strb = S[7:4], data = D[63:32].
- Cross-word store: S[7:4] != 0.
- Transitions:
  - IDLE -> BEAT0 on accept of a legal, non-dropped request.
  - BEAT0 -> BEAT1 on handshake if cross-word; otherwise BEAT0 -> IDLE.
  - BEAT1 -> IDLE on handshake.
- Handshake: a beat completes on the cycle with Mem_valid_o && Mem_ready_i. While Mem_ready_i is low, Mem_addr_o, Mem_data_o and Mem_strb_o hold stable and Mem_valid_o stays high; it is never withdrawn.
- Illegal size (2'b11): the request is accepted, no beat is issued, Store_err_o pulses, and the block stays in IDLE.
- Mem_valid_o is never asserted with Mem_strb_o == 0.

## Timing
- Reset values: state IDLE, Req_ready_o 1, Mem_valid_o 0, Mem_addr_o 0, Mem_data_o 0, Mem_strb_o 0, Busy_o 0, Store_err_o 0.
- Latency: accept in cycle N -> Mem_valid_o high in cycle N+1 (registered outputs).
- Single-beat store with Mem_ready_i held high: IDLE again at N+2, so the next accept is at N+2 at the earliest.
- Split store with Mem_ready_i held high: BEAT1 valid at N+2, IDLE at N+3.
- Store_err_o is registered and pulses high in cycle N+1 for one cycle.
- Reset asserted mid-beat: outputs return asynchronously to their reset values and any in-flight beat is abandoned. The memory side must tolerate a valid that drops without a handshake only in this case.
- Req_valid_i while not ready: ignored; the requester must hold the request until accepted.

## Configuration
- SPLIT_MISALIGNED_EN defined: cross-word stores are split into BEAT0 + BEAT1 as described above.
- SPLIT_MISALIGNED_EN undefined:
  - The BEAT1 state and its logic are compiled out.
  - A cross-word request is accepted and dropped with a Store_err_o pulse; no beat is issued.
  - Word-contained misaligned stores (e.g. Half at off = 1) still complete normally.

## Test plan
- SW, Addr 0x100, Data 0xDEADBEEF, Mem_ready_i = 1 -> one beat: addr 0x100, strb 4'b1111, data 0xDEADBEEF; Req_ready_o back high 2 cycles after accept.
- SB, Addr 0x103, Data 0x123456AB -> one beat: addr 0x100, strb 4'b1000, data 0xAB000000.
- SH, Addr 0x203, Data 0x0000CAFE, with SPLIT_MISALIGNED_EN:
  - beat 1: addr 0x200, strb 4'b1000, data 0xFE000000.
  - beat 2: addr 0x204, strb 4'b0001, data 0x000000CA.
  - Without the macro: Store_err_o pulse, no Mem_valid_o.
- SW, Addr 0xFFFFFFFE, Data 0x11223344, with SPLIT_MISALIGNED_EN:
  - beat 1: addr 0xFFFFFFFC, strb 4'b1100, data 0x33440000.
  - beat 2: addr 0x00000000, strb 4'b0011, data 0x00001122.
- Stall: hold Mem_ready_i low 3 cycles during SW at 0x40 -> Mem_* outputs stable and Req_ready_o 0 for all 3 cycles; completes on the first ready cycle. Size 2'b11 -> Store_err_o single-cycle pulse, no beat.
- Assert rst_i during BEAT1 of a split store -> Mem_valid_o falls immediately; after release Req_ready_o = 1, Busy_o = 0, and a new SW completes normally.
